trigger_receiver: RTL and testbench

Detector-side end of the synchronization link. Takes the asynchronous frame-grabber strobe and detector trigger and synchronizes both. It measures the fg-to-trigger delay in clock cycles, qualifies the trigger pulse width and checks the delay against an expected window. It reports valid triggers, timing errors and counts to the detector control logic and status registers.

---
 rtl/sync_block_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/trigger_receiver.sv | 146 ++++++++++++++
 tb/tb_trigger_receiver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_block_pkg.sv
// sync_block_pkg: types and default timing constants shared by the trigger generator and receiver
//   rx_state_t       receiver state encoding
//   DEF_*            default delay window and qualification constants
package sync_block_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_QUALIFY,
        S_HOLDOFF
    } rx_state_t;

    localparam int unsigned DEF_EXPECTED_DELAY = 450_000;
    localparam int unsigned DEF_TOLERANCE      = 16;
    localparam int unsigned DEF_MIN_WIDTH      = 2;
    localparam int unsigned DEF_HOLDOFF        = 1000;
    localparam int unsigned DEF_CNT_W          = 32;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer with registered level and rising-edge pulse
//   clock     system clock
//   reset     synchronous active-high reset
//   async_in  asynchronous input
//   level     synchronized level, aligned with rise
//   rise      one-cycle pulse, 3 cycles after async_in rises
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta, sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta  <= async_in;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
        end
    end

endmodule

// File: rtl/trigger_receiver.sv
// trigger_receiver: measures and qualifies the fg-to-trigger delay on the detector side
//   clock, reset        system clock, synchronous active-high reset
//   fg_signal           asynchronous frame-grabber strobe
//   detector_trigger    asynchronous trigger from the sync block
//   trigger_valid       pulse on a qualified trigger
//   measured_delay      delay of the last qualified trigger
//   early_error         pulse with trigger_valid when the delay is below the window
//   late_error          pulse when no trigger edge arrives by the window end
//   glitch_error        pulse when the trigger is shorter than MIN_WIDTH
//   stray_error         pulse on a trigger edge while not armed
//   trigger_count       qualified trigger count, wrapping
//   busy                high whenever not idle
module trigger_receiver
    import sync_block_pkg::*;
#(
    parameter int unsigned EXPECTED_DELAY = DEF_EXPECTED_DELAY,
    parameter int unsigned TOLERANCE      = DEF_TOLERANCE,
    parameter int unsigned MIN_WIDTH      = DEF_MIN_WIDTH,
    parameter int unsigned HOLDOFF        = DEF_HOLDOFF,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fg_signal,
    input  logic             detector_trigger,
    output logic             trigger_valid,
    output logic [CNT_W-1:0] measured_delay,
    output logic             early_error,
    output logic             late_error,
    output logic             glitch_error,
    output logic             stray_error,
    output logic [15:0]      trigger_count,
    output logic             busy
);

    localparam int HW = $clog2(MIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] LATE_AT     = CNT_W'(EXPECTED_DELAY + TOLERANCE + 1);
    localparam logic [CNT_W-1:0] EARLY_BELOW = CNT_W'(EXPECTED_DELAY - TOLERANCE);
    localparam logic [CNT_W-1:0] HOLD_LEN    = CNT_W'(HOLDOFF);
    localparam logic [HW-1:0]    RUN_DONE    = HW'(MIN_WIDTH);

    if (MIN_WIDTH == 0 || HOLDOFF == 0 || TOLERANCE > EXPECTED_DELAY ||
        ((64'(EXPECTED_DELAY) + 64'(TOLERANCE) + 64'd1) >> CNT_W) != 64'd0) begin : g_bad_params
        $error("trigger_receiver: invalid parameter set");
    end

    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cand, cand_n;
    logic [HW-1:0]    run, run_n;
    logic             fg_rise, trig_rise, trig_level, unused_fg_level;
    logic             qualify, early_p, late_p, glitch_p, stray_p;

    sync_edge_detect u_fg_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (fg_signal),
        .level    (unused_fg_level),
        .rise     (fg_rise)
    );

    sync_edge_detect u_trig_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (detector_trigger),
        .level    (trig_level),
        .rise     (trig_rise)
    );

    // cnt is the delay since the fg edge while measuring, and the elapsed dead time in HOLDOFF
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + ONE;
        cand_n   = cand;
        run_n    = run;
        qualify  = 1'b0;
        late_p   = 1'b0;
        glitch_p = 1'b0;
        stray_p  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n   = fg_rise ? ONE : cnt;
                state_n = fg_rise ? S_ARMED : S_IDLE;
                stray_p = trig_rise;
            end
            S_ARMED: begin
                if (trig_rise) begin
                    cand_n  = cnt;
                    run_n   = HW'(1);
                    qualify = (MIN_WIDTH == 1);
                    state_n = S_QUALIFY;
                end else if (cnt >= LATE_AT) begin
                    late_p  = 1'b1;
                    state_n = S_IDLE;
                end else if (fg_rise) begin
                    cnt_n = ONE;
                end
            end
            S_QUALIFY: begin
                if (trig_level) begin
                    run_n   = run + HW'(1);
                    qualify = (run_n == RUN_DONE);
                end else begin
                    glitch_p = 1'b1;
                    state_n  = S_ARMED;
                end
            end
            S_HOLDOFF: state_n = (cnt == HOLD_LEN) ? S_IDLE : S_HOLDOFF;
            default:   state_n = S_IDLE;
        endcase
        if (qualify) begin
            state_n = S_HOLDOFF;
            cnt_n   = ONE;
        end
        early_p = qualify && (cand_n < EARLY_BELOW);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            cand           <= '0;
            run            <= '0;
            measured_delay <= '0;
            trigger_count  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
            run   <= run_n;
            if (qualify) begin
                measured_delay <= cand_n;
                trigger_count  <= trigger_count + 16'd1;
            end
        end
    end

    // pulses are suppressed while reset is asserted so an abandoned measurement reports nothing
    assign trigger_valid = qualify  & ~reset;
    assign early_error   = early_p  & ~reset;
    assign late_error    = late_p   & ~reset;
    assign glitch_error  = glitch_p & ~reset;
    assign stray_error   = stray_p  & ~reset;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_trigger_receiver.sv
// tb_trigger_receiver: directed stimulus checked against a timestamp-based behavioural model
module tb_trigger_receiver;

    localparam int ED  = 100;
    localparam int TOL = 4;
    localparam int MW  = 3;
    localparam int HO  = 20;

    localparam int M_IDLE = 0;
    localparam int M_ARMED = 1;
    localparam int M_QUAL = 2;
    localparam int M_HOLD = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fg_signal = 1'b0;
    logic        detector_trigger = 1'b0;
    logic        trigger_valid, early_error, late_error, glitch_error, stray_error, busy;
    logic [31:0] measured_delay;
    logic [15:0] trigger_count;

    trigger_receiver #(
        .EXPECTED_DELAY (ED),
        .TOLERANCE      (TOL),
        .MIN_WIDTH      (MW),
        .HOLDOFF        (HO),
        .CNT_W          (32)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .fg_signal        (fg_signal),
        .detector_trigger (detector_trigger),
        .trigger_valid    (trigger_valid),
        .measured_delay   (measured_delay),
        .early_error      (early_error),
        .late_error       (late_error),
        .glitch_error     (glitch_error),
        .stray_error      (stray_error),
        .trigger_count    (trigger_count),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int       cyc = 0;
    bit       started = 1'b0;
    logic [3:0] f_hist = '0;
    logic [3:0] t_hist = '0;

    // input history as seen at each clock; index 2 is the synchronized level, 2 vs 3 gives the edge
    always @(posedge clock) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
        f_hist  <= reset ? 4'b0 : {f_hist[2:0], fg_signal};
        t_hist  <= reset ? 4'b0 : {t_hist[2:0], detector_trigger};
    end

    int          m_state = M_IDLE;
    int          m_fg = 0, m_cand = 0, m_run = 0, m_hold_end = 0;
    logic [31:0] m_md = '0;
    logic [15:0] m_count = '0;
    int          load_seq = 0, last_seq = 0;
    logic [15:0] load_val = '0;
    int n_valid = 0, n_early = 0, n_late = 0, n_glitch = 0, n_stray = 0;
    int valid_cyc = 0, late_cyc = 0, busy_last = 0;

    always @(negedge clock) begin
        logic lvl, tr, fr, ev, ee, el, eg, es;
        int   nxt, d;
        if (started) begin
            lvl = t_hist[2];
            tr  = t_hist[2] & ~t_hist[3];
            fr  = f_hist[2] & ~f_hist[3];
            {ev, ee, el, eg, es} = '0;
            nxt = m_state;
            d   = cyc - m_fg;
            if (load_seq != last_seq) begin
                m_count  = load_val;
                last_seq = load_seq;
            end
            case (m_state)
                M_IDLE: begin
                    es = tr;
                    if (fr) begin
                        nxt  = M_ARMED;
                        m_fg = cyc;
                    end
                end
                M_ARMED: begin
                    if (tr) begin
                        m_cand = d;
                        m_run  = 1;
                        nxt    = M_QUAL;
                    end else if (d >= ED + TOL + 1) begin
                        el  = 1'b1;
                        nxt = M_IDLE;
                    end else if (fr) begin
                        m_fg = cyc;
                    end
                end
                M_QUAL: begin
                    if (lvl) begin
                        m_run++;
                        if (m_run == MW) begin
                            ev = 1'b1;
                            ee = (m_cand < ED - TOL);
                            nxt = M_HOLD;
                            m_hold_end = cyc + HO;
                        end
                    end else begin
                        eg  = 1'b1;
                        nxt = M_ARMED;
                    end
                end
                default: if (cyc == m_hold_end) nxt = M_IDLE;
            endcase
            chk("trigger_valid", trigger_valid, ev & ~reset);
            chk("early_error", early_error, ee & ~reset);
            chk("late_error", late_error, el & ~reset);
            chk("glitch_error", glitch_error, eg & ~reset);
            chk("stray_error", stray_error, es & ~reset);
            chk("measured_delay", measured_delay, m_md);
            chk("trigger_count", trigger_count, m_count);
            chk("busy", busy, m_state != M_IDLE);
            if (trigger_valid) begin n_valid++; valid_cyc = cyc; end
            if (late_error) begin n_late++; late_cyc = cyc; end
            if (early_error) n_early++;
            if (glitch_error) n_glitch++;
            if (stray_error) n_stray++;
            if (busy) busy_last = cyc;
            if (reset) begin
                m_state = M_IDLE;
                m_md    = '0;
                m_count = '0;
            end else begin
                if (ev) begin
                    m_md = m_cand;
                    m_count++;
                end
                m_state = nxt;
            end
        end
    end

    int fg_cyc = 0;
    int b_valid, b_early, b_late, b_glitch, b_stray;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic snap();
        b_valid = n_valid; b_early = n_early; b_late = n_late; b_glitch = n_glitch; b_stray = n_stray;
    endtask

    // fg high for 10 cycles from fa (none if fa<0); trigger pulses [t1,t1+w1) and [t2,t2+w2)
    task automatic drive(input int fa, input int t1, input int w1, input int t2, input int w2, input int total);
        for (int i = 0; i < total; i++) begin
            fg_signal = (fa >= 0) && (i >= fa) && (i < fa + 10);
            detector_trigger = ((i >= t1) && (i < t1 + w1)) || ((i >= t2) && (i < t2 + w2));
            if (i == fa) fg_cyc = cyc;
            step(1);
        end
        fg_signal = 1'b0;
        detector_trigger = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        step(3);
        reset = 1'b0;
        step(2);
        chk("reset measured_delay", measured_delay, 0);
        chk("reset trigger_count", trigger_count, 0);
        chk("reset busy", busy, 0);

        snap();
        drive(0, 100, 5, 0, 0, 130);
        chk("t1 valid pulses", n_valid - b_valid, 1);
        chk("t1 error pulses", (n_early - b_early) + (n_late - b_late) + (n_glitch - b_glitch) + (n_stray - b_stray), 0);
        chk("t1 measured_delay", measured_delay, 100);
        chk("t1 trigger_count", trigger_count, 1);
        chk("t1 valid cycle after fg", valid_cyc - fg_cyc, 105);
        chk("t1 busy cycles after valid", busy_last - valid_cyc, HO);
        chk("t1 busy idle", busy, 0);

        snap();
        drive(0, 96, 5, 0, 0, 130);
        chk("t2a valid pulses", n_valid - b_valid, 1);
        chk("t2a early pulses", n_early - b_early, 0);
        chk("t2a measured_delay", measured_delay, 96);
        snap();
        drive(0, 95, 5, 0, 0, 130);
        chk("t2b valid pulses", n_valid - b_valid, 1);
        chk("t2b early pulses", n_early - b_early, 1);
        chk("t2b measured_delay", measured_delay, 95);
        chk("t2b trigger_count", trigger_count, 3);

        snap();
        drive(0, 0, 0, 0, 0, 130);
        chk("t3 late pulses", n_late - b_late, 1);
        chk("t3 late cycle after fg", late_cyc - fg_cyc, 108);
        chk("t3 valid pulses", n_valid - b_valid, 0);
        chk("t3 trigger_count", trigger_count, 3);
        chk("t3 busy idle", busy, 0);

        snap();
        drive(0, 98, 2, 102, 4, 130);
        chk("t4 glitch pulses", n_glitch - b_glitch, 1);
        chk("t4 valid pulses", n_valid - b_valid, 1);
        chk("t4 measured_delay", measured_delay, 102);
        chk("t4 trigger_count", trigger_count, 4);

        snap();
        drive(-1, 5, 3, 0, 0, 20);
        chk("t5a stray pulses", n_stray - b_stray, 1);
        chk("t5a busy idle", busy, 0);
        snap();
        drive(0, 100, 5, 112, 5, 140);
        chk("t5b valid pulses", n_valid - b_valid, 1);
        chk("t5b stray pulses", n_stray - b_stray, 0);
        chk("t5b trigger_count", trigger_count, 5);

        snap();
        drive(0, 100, 4, 0, 0, 104);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6 busy after reset", busy, 0);
        chk("t6 measured_delay after reset", measured_delay, 0);
        chk("t6 trigger_count after reset", trigger_count, 0);
        step(10);
        chk("t6 pulses around reset", (n_valid - b_valid) + (n_early - b_early) + (n_late - b_late) + (n_glitch - b_glitch) + (n_stray - b_stray), 0);

        load_val = 16'hFFFE;
        force u_dut.trigger_count = 16'hFFFE;
        load_seq++;
        step(1);
        release u_dut.trigger_count;
        step(1);
        chk("wrap preload", trigger_count, 16'hFFFE);
        snap();
        drive(0, 100, 5, 0, 0, 130);
        chk("wrap count at max", trigger_count, 16'hFFFF);
        drive(0, 100, 5, 0, 0, 130);
        chk("wrap count rolled over", trigger_count, 0);
        chk("wrap valid pulses", n_valid - b_valid, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
